diag_shift_engine: RTL and testbench

DIAG_SHIFT_ENGINE -- requirements
Module: diag_shift_engine

---
 rtl/diag_shift_engine_pkg.sv | 21 ++
 rtl/diag_shift_engine_if.sv | 28 ++
 rtl/diag_shift_engine_step.sv | 39 +++
 rtl/diag_shift_engine.sv | 112 +++++++++++
 tb/tb_diag_shift_engine.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/diag_shift_engine_pkg.sv
// Shared encodings for the diagonal shift engine: step directions, FSM states
// and the default board geometry.
package diag_shift_engine_pkg;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 4;

    typedef enum logic [1:0] {
        DIR_UR = 2'b00,
        DIR_UL = 2'b01,
        DIR_DR = 2'b10,
        DIR_DL = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/diag_shift_engine_if.sv
// Request/result bundle of the diagonal shift engine. Both sides use strict
// valid/ready: a beat moves only on a clock edge where valid && ready are both 1,
// and an offered beat keeps its payload stable until it moves.
interface diag_shift_engine_if #(
    parameter int W  = 32,
    parameter int SW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_board;
    logic [1:0]    in_dir;
    logic [SW-1:0] in_steps;
    logic          in_fill;
    logic          in_accum;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_board;

    modport slave (
        input  in_valid, in_board, in_dir, in_steps, in_fill, in_accum, out_ready,
        output in_ready, out_valid, out_board
    );

    modport master (
        output in_valid, in_board, in_dir, in_steps, in_fill, in_accum, out_ready,
        input  in_ready, out_valid, out_board
    );
endinterface

// File: rtl/diag_shift_engine_step.sv
// One combinational diagonal step on a checkerboard bitboard: each square takes
// the value of its neighbour opposite to the direction, or fill when off-board.
module diag_step
    import diag_shift_engine_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic [ROWS*COLS-1:0] src,
    input  dir_t                 dir,
    input  logic                 fill,
    output logic [ROWS*COLS-1:0] dst
);
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            // Even rows are offset right of odd rows, so the diagonal columns differ by parity.
            localparam int  CL    = (r % 2 == 0) ? c : c - 1;
            localparam int  CR    = (r % 2 == 0) ? c + 1 : c;
            localparam bit  L_OK  = (CL >= 0);
            localparam bit  R_OK  = (CR < COLS);
            localparam bit  DN_OK = (r + 1 < ROWS);
            localparam bit  UP_OK = (r > 0);
            localparam int  I_DL  = (DN_OK && L_OK) ? (r + 1) * COLS + CL : 0;
            localparam int  I_DR  = (DN_OK && R_OK) ? (r + 1) * COLS + CR : 0;
            localparam int  I_UL  = (UP_OK && L_OK) ? (r - 1) * COLS + CL : 0;
            localparam int  I_UR  = (UP_OK && R_OK) ? (r - 1) * COLS + CR : 0;

            logic from_dl, from_dr, from_ul, from_ur;
            assign from_dl = (DN_OK && L_OK) ? src[I_DL] : fill;
            assign from_dr = (DN_OK && R_OK) ? src[I_DR] : fill;
            assign from_ul = (UP_OK && L_OK) ? src[I_UL] : fill;
            assign from_ur = (UP_OK && R_OK) ? src[I_UR] : fill;

            assign dst[r*COLS+c] = (dir == DIR_UR) ? from_dl :
                                   (dir == DIR_UL) ? from_dr :
                                   (dir == DIR_DR) ? from_ul : from_ur;
        end
    end
endmodule

// File: rtl/diag_shift_engine.sv
// Multi-cycle diagonal shift engine: accepts a board, applies up to MAX_STEPS
// single diagonal steps (one per clock) and holds the result until taken.
module diag_shift_engine
    import diag_shift_engine_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int MAX_STEPS = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    diag_shift_engine_if.slave bus,
    output state_t             dbg_state
);
    localparam int W  = ROWS * COLS;
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_STEPS);
    localparam logic [SW-1:0] ONE_S = SW'(1);

    state_t        state;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  out_board_q;
    logic [W-1:0]  work_q;
    logic [W-1:0]  acc_q;
    dir_t          dir_q;
    logic          fill_q;
    logic          accum_q;
    logic [SW-1:0] steps_q;

    logic [W-1:0]  step_dst;
    logic [W-1:0]  step_acc;
    logic [SW-1:0] steps_sat;

    assign steps_sat = (bus.in_steps > MAX_S) ? MAX_S : bus.in_steps;
    assign step_acc  = acc_q | step_dst;

    diag_step #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_step (
        .src  (work_q),
        .dir  (dir_q),
        .fill (fill_q),
        .dst  (step_dst)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_board_q <= '0;
            work_q      <= '0;
            acc_q       <= '0;
            dir_q       <= DIR_UR;
            fill_q      <= 1'b0;
            accum_q     <= 1'b0;
            steps_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        work_q     <= bus.in_board;
                        acc_q      <= '0;
                        dir_q      <= dir_t'(bus.in_dir);
                        fill_q     <= bus.in_fill;
                        accum_q    <= bus.in_accum;
                        steps_q    <= steps_sat;
                        in_ready_q <= 1'b0;
                        if (steps_sat == '0) begin
                            out_board_q <= bus.in_board;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q  <= step_dst;
                    acc_q   <= step_acc;
                    steps_q <= steps_q - ONE_S;
                    // Last step: publish straight from the step output, no extra cycle.
                    if (steps_q == ONE_S) begin
                        out_board_q <= accum_q ? step_acc : step_dst;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // in_ready stays low through the release edge, so no same-cycle accept.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_board = out_board_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_diag_shift_engine.sv
// Directed bench for diag_shift_engine: expected boards are queued at accept
// and compared when the engine presents its result.
module tb_diag_shift_engine;
    import diag_shift_engine_pkg::*;

    localparam int ROWS      = 8;
    localparam int COLS      = 4;
    localparam int MAX_STEPS = 2;
    localparam int W         = ROWS * COLS;
    localparam int SW        = 2;

    logic   clock   = 1'b0;
    logic   reset_n = 1'b0;
    state_t dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    diag_shift_engine_if #(.W(W), .SW(SW)) bus ();

    diag_shift_engine #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: offer one request, queue its expected board, check result latency
    task automatic send(input logic [W-1:0] board, input logic [1:0] dir, input logic [SW-1:0] steps,
                        input logic fill, input logic accum, input logic [W-1:0] expected);
        int waited;
        int lat;
        int exp_lat;
        exp_lat = ((int'(steps) > MAX_STEPS) ? MAX_STEPS : int'(steps)) + 1;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_board = board;
        bus.in_dir   = dir;
        bus.in_steps = steps;
        bus.in_fill  = fill;
        bus.in_accum = accum;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("accept_ready", W'(bus.in_ready), W'(1));
        @(posedge clock);
        exp_q.push_back(expected);
        #1;
        // Scrambled inputs while busy must not disturb the result.
        bus.in_valid = 1'b0;
        bus.in_board = W'($urandom);
        bus.in_dir   = 2'($urandom_range(0, 3));
        bus.in_fill  = 1'($urandom_range(0, 1));
        bus.in_accum = 1'($urandom_range(0, 1));
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 20);
        check("latency", W'(lat), W'(exp_lat));
    endtask

    // scoreboard: hold off the result, then pop and compare, then release
    task automatic receive(input int hold);
        logic [W-1:0] first;
        logic [W-1:0] exp;
        first = bus.out_board;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_board", bus.out_board, first);
            check("hold_in_ready", W'(bus.in_ready), W'(0));
            check("hold_out_valid", W'(bus.out_valid), W'(1));
        end
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("result", bus.out_board, exp);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_steps  = 2'd1;
        bus.in_board  = W'($urandom);
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("release_state", W'(dbg_state), W'(ST_IDLE));
        check("release_out_valid", W'(bus.out_valid), W'(0));
        check("release_in_ready", W'(bus.in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] rnd;
        bus.in_valid  = 1'b0;
        bus.in_board  = '0;
        bus.in_dir    = 2'b00;
        bus.in_steps  = '0;
        bus.in_fill   = 1'b0;
        bus.in_accum  = 1'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_in_ready", W'(bus.in_ready), W'(1));
        check("reset_out_valid", W'(bus.out_valid), W'(0));
        check("reset_out_board", bus.out_board, '0);
        check("reset_state", W'(dbg_state), W'(ST_IDLE));
        reset_n = 1'b1;

        send(32'h0000_0000, 2'b00, 2'd1, 1'b1, 1'b0, 32'hF010_1010); receive(0);
        send(32'h0000_0010, 2'b00, 2'd1, 1'b1, 1'b0, 32'hF010_1011); receive(0);
        send(32'h0000_0010, 2'b00, 2'd1, 1'b0, 1'b0, 32'h0000_0001); receive(0);
        send(32'h0000_0200, 2'b00, 2'd2, 1'b0, 1'b0, 32'h0000_0004); receive(0);
        send(32'h0000_0001, 2'b11, 2'd2, 1'b0, 1'b1, 32'h0000_0010); receive(0);
        send(32'h0000_0001, 2'b11, 2'd2, 1'b0, 1'b0, 32'h0000_0000); receive(0);
        send(32'h0000_0200, 2'b00, 2'd2, 1'b0, 1'b1, 32'h0000_0044); receive(0);
        send(32'h0000_0200, 2'b00, 2'd3, 1'b0, 1'b0, 32'h0000_0004); receive(0);
        rnd = W'($urandom);
        send(rnd,           2'b10, 2'd0, 1'b1, 1'b1, rnd);          receive(0);
        send(32'h0000_0000, 2'b01, 2'd1, 1'b1, 1'b0, 32'hF808_0808); receive(0);
        send(32'h0000_0001, 2'b10, 2'd1, 1'b0, 1'b0, 32'h0000_0020); receive(0);
        send(32'h0000_0200, 2'b00, 2'd1, 1'b0, 1'b0, 32'h0000_0040); receive(5);

        // reset in the middle of a two-step shift
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_board = 32'h0000_0200;
        bus.in_dir   = 2'b00;
        bus.in_steps = 2'd2;
        bus.in_fill  = 1'b0;
        bus.in_accum = 1'b0;
        @(posedge clock);
        exp_q.push_back(32'h0000_0004);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("midshift_state", W'(dbg_state), W'(ST_SHIFT));
        reset_n = 1'b0;
        #1;
        check("midreset_in_ready", W'(bus.in_ready), W'(1));
        check("midreset_out_valid", W'(bus.out_valid), W'(0));
        check("midreset_out_board", bus.out_board, '0);
        check("midreset_state", W'(dbg_state), W'(ST_IDLE));
        exp_q.delete();
        repeat (3) @(negedge clock);
        check("inreset_out_valid", W'(bus.out_valid), W'(0));
        reset_n = 1'b1;
        send(32'h0000_0000, 2'b00, 2'd1, 1'b1, 1'b0, 32'hF010_1010); receive(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
